// File: rtl/cpl_tag_tracker.sv
// Completion table: reassembles R/B completion entries per tag and serves
// tag/beat queries and tag releases for the APB readback side.
module cpl_tag_tracker #(
  parameter int TAG_NUM       = 16,
  parameter int TAG_W         = 4,
  parameter int DATA_W        = 32,
  parameter int MAX_BEATS_NUM = 16,
  parameter int BEAT_W        = 5,
  parameter int FIFO_W        = 3 + TAG_W + DATA_W + 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                cpl_valid,
  input  logic [FIFO_W-1:0]   cpl_data,
  output logic                cpl_ready,
  input  logic [TAG_W-1:0]    q_tag,
  input  logic [BEAT_W-2:0]   q_beat,
  output logic                q_done,
  output logic                q_is_write,
  output logic [1:0]          q_resp,
  output logic [BEAT_W-1:0]   q_beats,
  output logic [DATA_W-1:0]   q_data,
  input  logic                rel_valid,
  input  logic [TAG_W-1:0]    rel_tag,
  output logic [TAG_NUM-1:0]  done_vec,
  output logic                err_overflow
);

  localparam int IDX_W = TAG_W + BEAT_W - 1;
  localparam logic [BEAT_W-1:0] MAX_B = BEAT_W'(MAX_BEATS_NUM);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} tag_st_e;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic                in_wr;
  logic [TAG_W-1:0]    in_tag;
  logic [1:0]          in_resp;
  logic                in_last;
  logic [DATA_W-1:0]   in_data;

  assign in_wr   = cpl_data[FIFO_W-1];
  assign in_tag  = cpl_data[DATA_W+3 +: TAG_W];
  assign in_resp = cpl_data[DATA_W+2:DATA_W+1];
  assign in_last = cpl_data[DATA_W];
  assign in_data = cpl_data[DATA_W-1:0];

  tag_st_e           st_p0    [TAG_NUM];
  logic [1:0]        resp_p0  [TAG_NUM];
  logic [BEAT_W-1:0] beats_p0 [TAG_NUM];
  logic              wr_p0    [TAG_NUM];

  tag_st_e           st_nx    [TAG_NUM];
  logic [1:0]        resp_nx  [TAG_NUM];
  logic [BEAT_W-1:0] beats_nx [TAG_NUM];
  logic              wr_nx    [TAG_NUM];

  logic [DATA_W-1:0] mem [TAG_NUM*MAX_BEATS_NUM];

  logic             run;
  logic             push;
  logic             rel_err;
  logic             ovf;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [IDX_W-1:0] q_idx;

  // Head-of-line stall: a DONE tag at the head blocks until it is released.
  assign cpl_ready = run && !((st_p0[in_tag] == DONE) &&
                              !(rel_valid && (rel_tag == in_tag)));
  assign push  = cpl_valid && cpl_ready;
  assign q_idx = {q_tag, q_beat};

  always_comb begin
    for (int i = 0; i < TAG_NUM; i++) begin
      st_nx[i]    = st_p0[i];
      resp_nx[i]  = resp_p0[i];
      beats_nx[i] = beats_p0[i];
      wr_nx[i]    = wr_p0[i];
      done_vec[i] = (st_p0[i] == DONE);
    end
    rel_err = 1'b0;
    ovf     = 1'b0;
    mem_we  = 1'b0;
    mem_idx = '0;

    // Release is applied first so a same-tag push sees the tag as IDLE.
    if (rel_valid) begin
      if (st_p0[rel_tag] == DONE) begin
        st_nx[rel_tag]    = IDLE;
        resp_nx[rel_tag]  = 2'b00;
        beats_nx[rel_tag] = '0;
        wr_nx[rel_tag]    = 1'b0;
      end else begin
        rel_err = 1'b1;
      end
    end

    if (push) begin
      case (st_nx[in_tag])
        IDLE: begin
          resp_nx[in_tag] = in_resp;
          if (in_wr) begin
            st_nx[in_tag]    = DONE;
            wr_nx[in_tag]    = 1'b1;
            beats_nx[in_tag] = '0;
          end else begin
            mem_we           = 1'b1;
            mem_idx          = {in_tag, {(BEAT_W-1){1'b0}}};
            beats_nx[in_tag] = BEAT_W'(1);
            st_nx[in_tag]    = in_last ? DONE : COLLECT;
          end
        end
        COLLECT: begin
          if (!in_wr) begin
            if (beats_nx[in_tag] == MAX_B) begin
              ovf             = 1'b1;
              st_nx[in_tag]   = DONE;
              resp_nx[in_tag] = 2'b10;
            end else begin
              mem_we           = 1'b1;
              mem_idx          = {in_tag, beats_nx[in_tag][BEAT_W-2:0]};
              beats_nx[in_tag] = beats_nx[in_tag] + 1'b1;
              resp_nx[in_tag]  = resp_max(resp_nx[in_tag], in_resp);
              if (in_last) st_nx[in_tag] = DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Table / query stage: query sees the state produced by this same edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < TAG_NUM; i++) begin
        st_p0[i]    <= IDLE;
        resp_p0[i]  <= 2'b00;
        beats_p0[i] <= '0;
        wr_p0[i]    <= 1'b0;
      end
      run          <= 1'b0;
      err_overflow <= 1'b0;
      q_done       <= 1'b0;
      q_is_write   <= 1'b0;
      q_resp       <= 2'b00;
      q_beats      <= '0;
      q_data       <= '0;
    end else begin
      for (int i = 0; i < TAG_NUM; i++) begin
        st_p0[i]    <= st_nx[i];
        resp_p0[i]  <= resp_nx[i];
        beats_p0[i] <= beats_nx[i];
        wr_p0[i]    <= wr_nx[i];
      end
      run          <= 1'b1;
      err_overflow <= rel_err | ovf;
      q_done       <= (st_nx[q_tag] == DONE);
      q_is_write   <= wr_nx[q_tag];
      q_resp       <= resp_nx[q_tag];
      q_beats      <= beats_nx[q_tag];
      q_data       <= (mem_we && (mem_idx == q_idx)) ? in_data : mem[q_idx];
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) mem[mem_idx] <= in_data;
  end

endmodule
